// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the EX-stage DIV/DIVU path.
//
// It accepts an operand pair when start_i is high in FREE. It then resolves one
// quotient bit per clock and presents {remainder, quotient} with ready_o. The
// result is held until EX drops start_i. annul_i cancels a division that is in
// flight. A zero divisor short-circuits to a zero result after a single cycle.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
//   opdata1_i     dividend; sampled at accept
//   opdata2_i     divisor; sampled at accept
//   start_i       level request from EX, held until ready_o is seen
//   annul_i       cancel an in-flight division
//   result_o      {remainder, quotient}, registered, zero unless ready_o
//   ready_o       result valid, registered
//   busy_o        division in progress (BYZERO or ON), decoded from state
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rem_q;    // partial remainder
  logic [DATA_W-1:0]   dvd_q;    // dividend bits still to consume; quotient bits fill in from the LSB
  logic [DATA_W-1:0]   dvs_q;    // divisor magnitude
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  // Operand magnitudes at accept. The most negative value negates to itself.
  // Its bit pattern is then used as an unsigned magnitude, which is the
  // correct value.
  logic [DATA_W-1:0] abs1, abs2;
  logic              op1_neg, op2_neg;

  always_comb begin
    op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    abs1    = op1_neg ? -opdata1_i : opdata1_i;
    abs2    = op2_neg ? -opdata2_i : opdata2_i;
  end

  // One restoring step. The shifted remainder is always below twice the
  // divisor, so a DATA_W+1 bit difference suffices. Its MSB is set exactly
  // when the trial subtraction goes negative.
  logic [DATA_W:0]   shifted, diff;
  logic              q_bit;
  logic [DATA_W-1:0] rem_d, dvd_d;

  always_comb begin
    shifted = {rem_q, dvd_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    q_bit   = ~diff[DATA_W];
    rem_d   = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    dvd_d   = {dvd_q[DATA_W-2:0], q_bit};
  end

  // Sign correction on the final magnitudes. The results wrap at DATA_W bits.
  logic [DATA_W-1:0] quo_fix, rem_fix;

  always_comb begin
    quo_fix = neg_quo_q ? -dvd_q : dvd_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          result_q <= '0;
          ready_q  <= 1'b0;
          if (start_i && !annul_i) begin
            rem_q     <= '0;
            dvd_q     <= abs1;
            dvs_q     <= abs2;
            neg_quo_q <= op1_neg ^ op2_neg;
            neg_rem_q <= op1_neg;
            cnt_q     <= '0;
            state_q   <= (opdata2_i == '0) ? BYZERO : ON;
          end
        end

        BYZERO: begin
          if (annul_i) begin
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= FREE;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end

        ON: begin
          if (annul_i) begin
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= FREE;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end

        END: begin
          // EX acknowledges the result by dropping start_i. annul_i is
          // ignored here because the result is already committed.
          if (!start_i) begin
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= FREE;
          end
        end

        default: begin
          result_q <= '0;
          ready_q  <= 1'b0;
          state_q  <= FREE;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == ON) || (state_q == BYZERO);

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
  endtask

  // Issue one division, measure edges from accept to ready_o, check the
  // result, then run the start_i drop handshake. With scramble set, the
  // operands and start_i are disturbed during ON.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit scramble);
    int edges;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk); #1;                       // E0
    chk({tag, "_busy_e0"}, busy_o, 1);
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready_o) begin edges = k; break; end
      if (scramble) begin
        if (k < 20) begin
          start_i = k[0];
          opdata1_i = $urandom; opdata2_i = $urandom;
          signed_div_i = ~signed_div_i;
        end else start_i = 1'b1;
      end
    end
    chk({tag, "_latency"}, edges, (b == 0) ? 1 : 33);
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_busy_end"}, busy_o, 0);
    @(posedge clk); #1;                       // start still high: hold
    chk({tag, "_hold_rdy"}, ready_o, 1);
    chk({tag, "_hold_res"}, result_o, exp);
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drop_rdy"}, ready_o, 0);
    chk({tag, "_drop_res"}, result_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk); rst = 1'b1;

    run_div("u100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 1'b0);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1'b0);
    run_div("u_fff9_2", 1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 1'b0);
    run_div("s_min_m1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0);
    run_div("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 1'b0);
    run_div("s5_0",     1'b1, 32'd5,          32'd0,          64'h0,                 1'b0);
    run_div("u5_0",     1'b0, 32'd5,          32'd0,          64'h0,                 1'b0);

    // Annul with cnt at 10 (after E10)
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);                           // E0
    repeat (10) @(posedge clk);
    #1;
    chk("annul_busy_pre", busy_o, 1);
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    chk("annul_busy", busy_o, 0);
    chk("annul_ready", ready_o, 0);
    chk("annul_result", result_o, 0);
    @(negedge clk); annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o || busy_o) seen = 1'b1;
    end
    chk("annul_quiet", seen, 0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);

    // Operand and start_i churn during ON: -100 / 7 signed
    run_div("s_scramble", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b1);

    // Async reset with cnt at 20, between edges
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);                           // E0
    repeat (20) @(posedge clk);
    #2;
    chk("arst_busy_pre", busy_o, 1);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", ready_o, 0);
    chk("arst_result", result_o, 0);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    run_div("u100_7_post", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle radix-2 restoring divider sequencer serving the execute stage's DIV/DIVU path. It accepts an operand pair, a signedness flag and a start level from EX. It then runs one quotient bit per clock and returns a 64-bit {remainder, quotient} word with a ready flag. EX holds its stall request while the result is not ready. The block also supports cancellation (annul) by the pipeline controller and detects divide-by-zero.

## Interface
- DATA_W, 32, operand width; the result is 2*DATA_W wide.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled only at accept.
- opdata1_i  input  DATA_W  dividend; sampled only at accept.
- opdata2_i  input  DATA_W  divisor; sampled only at accept.
- start_i  input  1  level request from EX; held high until ready_o is seen.
- annul_i  input  1  cancel an in-flight division (branch/flush).
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1, else 0.
- ready_o  output  1  result valid (registered).
- busy_o  output  1  decoded from state: high in BYZERO or ON.

## Operation
- States: FREE, BYZERO, ON, END. Reset state is FREE.
- All outputs are 0 during reset and in FREE.
- Accept: in FREE, start_i=1 and annul_i=0 at an edge.
  - Latch |opdata1| and |opdata2|. Magnitude is taken only when signed_div_i=1 and the MSB is 1, using two's complement; 0x80000000 stays 0x80000000, treated as unsigned.
  - Latch the sign flags and clear the iteration counter cnt (6 bits).
  - Next state: BYZERO if opdata2_i==0, else ON.
- In FREE, start_i with annul_i=1 is not accepted.
- ON, per edge with cnt<32: one restoring step.
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor using a DATA_W+1-bit difference.
  - If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - cnt++.
- ON, edge with cnt==32: apply sign correction, register result_o, set ready_o=1, go to END.
  - Quotient is negated iff signed and sign(op1)≠sign(op2).
  - Remainder is negated iff signed and op1 negative.
  - Results wrap at DATA_W bits, e.g. 0x80000000 / -1 signed gives q=0x80000000, r=0.
- BYZERO: next edge registers result_o=0, ready_o=1, goes to END.
- END: hold result_o and ready_o while start_i=1.
  - Edge with start_i=0 returns to FREE and clears result_o and ready_o.
  - annul_i has no effect in END.
- annul_i=1 in ON or BYZERO: next edge goes to FREE, cnt=0, result_o=0, ready_o stays 0.
- Operand and signedness changes after accept are ignored. start_i is ignored outside FREE and END.
- Async reset at any point, including mid-ON: immediately FREE with all outputs 0. No partial result survives.

## Timing
- Edge E0 accepts the request.
- Non-zero divisor: E1..E32 perform the 32 iterations. E33 enters END with ready_o=1, so ready_o is first high after E33.
- Zero divisor: E1 enters END, so ready_o is first high after E1.
- EX drops start_i in the cycle it sees ready_o=1. The following edge returns the block to FREE, and ready_o falls.
  - A new accept is possible at the edge after the block is back in FREE.
  - Minimum issue interval for back-to-back divides is 35 edges.
- annul_i sampled at edge Ek during ON/BYZERO takes effect at Ek; busy_o is low after Ek.
- No combinational path from inputs to result_o or ready_o. busy_o depends only on the state register.

## Test plan
- Unsigned 100 / 7, start held: ready_o rises after E33; result_o = 0x00000002_0000000E. Drop start_i: ready_o=0 and result_o=0 after the next edge.
- Signed -7 (0xFFFFFFF9) / 2: result_o = 0xFFFFFFFF_FFFFFFFD. Signed 0x80000000 / 0xFFFFFFFF: result_o = 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1: result_o = 0x00000000_FFFFFFFF.
- 5 / 0 (signed and unsigned): busy_o high for exactly one cycle; ready_o rises after E1; result_o = 0.
- Annul at cnt=10: next edge gives FREE with busy_o=0 and ready_o never asserted. A fresh 9/3 started next: result_o = 0x00000000_00000003 after 33 more edges.
- Operands change and start_i toggles while in ON: result matches the operands latched at E0; timing is unchanged.
- rst driven low asynchronously at cnt=20 (between edges): all outputs go to 0 immediately. After release, a new 100/7 completes normally.
